shift_unit_n: RTL and testbench
===============================

Name: shift_unit_n

Overview:
- Parametrised multi-mode shift register that generalises the fixed 8-bit mux-based shifter.
- Loads a WIDTH-bit word, then applies one of five shift/rotate operations for a programmable number of single-bit steps, one step per clock.
- Reports progress with a busy/done handshake.
- Sits in the datapath as a shared shifter; a controller issues start and waits for done.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- AMT_W, 3, width of the shift-amount field; maximum shift is 2**AMT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request: load d_in and begin the operation; sampled only in IDLE.
- op  input  3  operation select, sampled at start: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101-111 reserved.
- amt  input  AMT_W  number of single-bit steps, sampled at start.
- d_in  input  WIDTH  operand, sampled at start.
- s_in  input  1  serial fill bit for LSL/LSR; sampled live on every shift edge.
- q  output  WIDTH  shift register contents (registered).
- s_out  output  1  last bit shifted or rotated out (registered).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset_n=0, asynchronous, immediate): q=0, s_out=0, busy=0, done=0, internal count=0, state=IDLE.
- Reset mid-operation aborts the operation with no partial completion and no done pulse.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge T0:
  - q<=d_in; op latched; count<=amt.
  - busy<=1; done<=0; go to SHIFT.
- IDLE, start=0: everything holds; done<=0.
- SHIFT, count==0 (amt was 0): no shift. q and s_out unchanged; busy<=0; done<=1; go to IDLE.
- SHIFT, count>=1: perform one step, count<=count-1.
  - If count==1: busy<=0, done<=1, go to IDLE.
  - Otherwise remain in SHIFT.
- Step definitions (N=WIDTH):
  - LSL: q<={q[N-2:0],s_in}; s_out<=q[N-1].
  - LSR: q<={s_in,q[N-1:1]}; s_out<=q[0].
  - ASR: q<={q[N-1],q[N-1:1]}; s_out<=q[0].
  - ROL: q<={q[N-2:0],q[N-1]}; s_out<=q[N-1].
  - ROR: q<={q[0],q[N-1:1]}; s_out<=q[0].
  - Reserved codes: q and s_out hold, counting still proceeds, done still pulses.
- Latency:
  - done is high in the cycle after edge T0+max(amt,1).
  - busy is high from after T0 until the same edge that raises done.
- done lasts exactly one cycle; the unit is already in IDLE during the done cycle.
- Outside an operation, q and s_out hold their last values.
- start while busy=1 is ignored: no reload, no effect on count or op.
- start in the done cycle is accepted as a new operation (back-to-back issue).
- amt greater than WIDTH is legal: rotates wrap modulo WIDTH; logical shifts fill completely with s_in values.
- op, amt and d_in changing during SHIFT have no effect.

Test Plan:
- Reset: assert reset_n=0 mid-cycle with q non-zero -> q=0, busy=0, done=0, s_out=0 immediately, without waiting for a clock edge.
- LSL: d_in=8'b1011_0001, op=000, amt=3, s_in=0 -> busy for 3 cycles, then done pulse; q=8'b1000_1000, s_out=1.
- ASR then LSR fill:
  - d_in=8'b1001_0000, op=010, amt=2 -> q=8'b1110_0100, s_out=0.
  - Then d_in=8'h00, op=001, amt=4, s_in=1 -> q=8'hF0, s_out=0.
- Rotates:
  - d_in=8'h81, op=100, amt=1 -> q=8'hC0, s_out=1, done one cycle after start.
  - d_in=8'h01, op=011, amt=7 -> q=8'h80, s_out=0.
- Boundaries:
  - amt=0, d_in=8'h5A -> done one cycle after start, q=8'h5A, s_out unchanged.
  - start pulsed while busy -> ignored; final q matches the first operation.
  - start in the done cycle -> second operation runs correctly.
  - op=101 -> q unchanged, done still pulses after amt cycles.
- Reset mid-shift: assert reset_n=0 during cycle 2 of an amt=5 LSL -> q=0, busy=0, no done pulse; after release, a new start (d_in=8'h01, ROL, amt=1) gives q=8'h02.

Source files
------------

// File: rtl/shift_unit_n_if.sv
// Request/response bundle for the shared multi-mode shifter: the controller
// drives the operation fields, the shifter returns data and busy/done.
interface shift_unit_n_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) ();
    logic             start;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] d_in;
    logic             s_in;
    logic [WIDTH-1:0] q;
    logic             s_out;
    logic             busy;
    logic             done;

    modport master (
        output start, op, amt, d_in, s_in,
        input  q, s_out, busy, done
    );

    modport slave (
        input  start, op, amt, d_in, s_in,
        output q, s_out, busy, done
    );
endinterface

// File: rtl/shift_unit_n.sv
// Multi-mode shifter: loads a word and applies LSL/LSR/ASR/ROL/ROR one
// bit per clock for a programmable number of steps, with busy/done.
module shift_unit_n #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    shift_unit_n_if.slave bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [2:0]       OP_LSL   = 3'b000;
    localparam logic [2:0]       OP_LSR   = 3'b001;
    localparam logic [2:0]       OP_ASR   = 3'b010;
    localparam logic [2:0]       OP_ROL   = 3'b011;
    localparam logic [2:0]       OP_ROR   = 3'b100;
    localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
    localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    // One single-bit step; returns {bit shifted out, new word}. Reserved
    // codes return the word and previous serial bit untouched.
    function automatic logic [WIDTH:0] step_f(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] f_q,
        input logic             f_s_in,
        input logic             f_s_prev
    );
        logic [WIDTH:0] res;
        case (f_op)
            OP_LSL:  res = {f_q[WIDTH-1], f_q[WIDTH-2:0], f_s_in};
            OP_LSR:  res = {f_q[0], f_s_in, f_q[WIDTH-1:1]};
            OP_ASR:  res = {f_q[0], f_q[WIDTH-1], f_q[WIDTH-1:1]};
            OP_ROL:  res = {f_q[WIDTH-1], f_q[WIDTH-2:0], f_q[WIDTH-1]};
            OP_ROR:  res = {f_q[0], f_q[0], f_q[WIDTH-1:1]};
            default: res = {f_s_prev, f_q};
        endcase
        return res;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_s_out;
    logic             w_s_out_nxt;
    logic [AMT_W-1:0] r_count;
    logic [AMT_W-1:0] w_count_nxt;
    logic [2:0]       r_op;
    logic [2:0]       w_op_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [WIDTH:0]   w_step;

    assign w_step = step_f(r_op, r_q, bus.s_in, r_s_out);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a count of 0 or 1 means this SHIFT cycle is the last.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if ((r_count == CNT_ZERO) || (r_count == CNT_ONE)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values; done defaults low so it pulses for one cycle.
    always_comb begin
        w_q_nxt     = r_q;
        w_s_out_nxt = r_s_out;
        w_count_nxt = r_count;
        w_op_nxt    = r_op;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_q_nxt     = bus.d_in;
                    w_op_nxt    = bus.op;
                    w_count_nxt = bus.amt;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (r_count == CNT_ZERO) begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end else begin
                    {w_s_out_nxt, w_q_nxt} = w_step;
                    w_count_nxt            = r_count - CNT_ONE;
                    if (r_count == CNT_ONE) begin
                        w_busy_nxt = 1'b0;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_busy_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q     <= {WIDTH{1'b0}};
            r_s_out <= 1'b0;
            r_count <= CNT_ZERO;
            r_op    <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_q     <= w_q_nxt;
            r_s_out <= w_s_out_nxt;
            r_count <= w_count_nxt;
            r_op    <= w_op_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.q     = r_q;
    assign bus.s_out = r_s_out;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
endmodule

// File: tb/tb_shift_unit_n.sv
// Self-checking bench for shift_unit_n: directed table, hand-written corner
// sequences and random operations against a closed-form reference model.
module tb_shift_unit_n;
    localparam int N = 8;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    logic m_sout;

    shift_unit_n_if #(.WIDTH(N), .AMT_W(3)) bus ();

    shift_unit_n #(.WIDTH(N), .AMT_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [2:0] amt;
        logic [7:0] d;
        logic       s;
        logic [7:0] eq;
        logic       es;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Closed-form result of k steps: each output bit is read straight from the operand.
    function automatic logic [8:0] model(input int op, input int k, input logic [7:0] d,
                                         input logic s, input logic sprev);
        logic [7:0] r;
        logic       so;
        r  = d;
        so = sprev;
        if (k > 0) begin
            case (op)
                0: begin
                    for (int i = 0; i < N; i++) r[i] = (i >= k) ? d[i-k] : s;
                    so = (k <= N) ? d[N-k] : s;
                end
                1: begin
                    for (int i = 0; i < N; i++) r[i] = (i + k < N) ? d[i+k] : s;
                    so = (k <= N) ? d[k-1] : s;
                end
                2: begin
                    for (int i = 0; i < N; i++) r[i] = (i + k < N) ? d[i+k] : d[N-1];
                    so = (k <= N) ? d[k-1] : d[N-1];
                end
                3: begin
                    for (int i = 0; i < N; i++) r[i] = d[((i - k) % N + N) % N];
                    so = r[0];
                end
                4: begin
                    for (int i = 0; i < N; i++) r[i] = d[(i + k) % N];
                    so = r[N-1];
                end
                default: ;
            endcase
        end
        return {so, r};
    endfunction

    task automatic issue(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] d, input logic s);
        bus.op    = op;
        bus.amt   = amt;
        bus.d_in  = d;
        bus.s_in  = s;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Entered at the negedge after the accepting edge; returns at the done-cycle negedge.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [2:0] amt,
                          input logic [7:0] d, input logic s, input logic [7:0] eq,
                          input logic es, input bit b2b, input int poke_at);
        int n;
        bit busy_ok;
        int lat;
        n       = 0;
        busy_ok = 1'b1;
        lat     = (amt == 3'd0) ? 1 : int'(amt);
        issue(op, amt, d, s);
        while (n < 40) begin
            if (bus.done === 1'b1) break;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (n == poke_at) begin
                bus.start = 1'b1;
                bus.op    = 3'b100;
                bus.amt   = 3'd1;
                bus.d_in  = 8'hFF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_busy_during"}, busy_ok, 1'b1);
        chk({nm, "_busy_at_done"}, bus.busy, 1'b0);
        chk({nm, "_q"}, bus.q, eq);
        chk({nm, "_s_out"}, bus.s_out, es);
        m_sout = es;
        if (!b2b) begin
            @(negedge clk);
            chk({nm, "_done_one_cycle"}, bus.done, 1'b0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        logic [8:0] m;
        bit         seen_done;
        checks    = 0;
        failures  = 0;
        m_sout    = 1'b0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.amt   = 3'd0;
        bus.d_in  = 8'h00;
        bus.s_in  = 1'b0;

        vecs[0] = '{3'b000, 3'd3, 8'b1011_0001, 1'b0, 8'b1000_1000, 1'b1};
        vecs[1] = '{3'b010, 3'd2, 8'b1001_0000, 1'b0, 8'b1110_0100, 1'b0};
        vecs[2] = '{3'b001, 3'd4, 8'h00,        1'b1, 8'hF0,        1'b0};
        vecs[3] = '{3'b100, 3'd1, 8'h81,        1'b0, 8'hC0,        1'b1};
        vecs[4] = '{3'b011, 3'd7, 8'h01,        1'b0, 8'h80,        1'b0};
        vecs[5] = '{3'b000, 3'd0, 8'h5A,        1'b1, 8'h5A,        1'b0};
        vecs[6] = '{3'b101, 3'd4, 8'h3C,        1'b1, 8'h3C,        1'b0};
        vecs[7] = '{3'b111, 3'd6, 8'hA5,        1'b0, 8'hA5,        1'b0};

        @(negedge clk);
        @(negedge clk);
        chk("reset_q", bus.q, 8'h00);
        chk("reset_s_out", bus.s_out, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].d,
                   vecs[i].s, vecs[i].eq, vecs[i].es, 1'b0, -1);
        end

        // start while busy must not disturb the running LSL
        m = model(0, 4, 8'h0F, 1'b0, m_sout);
        run_op("busy_poke", 3'b000, 3'd4, 8'h0F, 1'b0, m[7:0], m[8], 1'b0, 2);

        // back-to-back: second start lands in the first done cycle
        m = model(0, 2, 8'h0F, 1'b1, m_sout);
        run_op("b2b_first", 3'b000, 3'd2, 8'h0F, 1'b1, m[7:0], m[8], 1'b1, -1);
        m = model(4, 3, 8'h96, 1'b0, m_sout);
        run_op("b2b_second", 3'b100, 3'd3, 8'h96, 1'b0, m[7:0], m[8], 1'b0, -1);

        // asynchronous reset during an amt=5 LSL
        issue(3'b000, 3'd5, 8'hFF, 1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_q", bus.q, 8'h00);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_s_out", bus.s_out, 1'b0);
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        chk("midrst_no_done", seen_done, 1'b0);
        m_sout = 1'b0;
        run_op("after_rst_rol", 3'b011, 3'd1, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] rop;
            logic [2:0] ramt;
            logic [7:0] rd;
            logic       rs;
            rop  = 3'($urandom_range(0, 7));
            ramt = 3'($urandom_range(0, 7));
            rd   = 8'($urandom);
            rs   = 1'($urandom_range(0, 1));
            m    = model(int'(rop), int'(ramt), rd, rs, m_sout);
            run_op($sformatf("rand%0d", i), rop, ramt, rd, rs, m[7:0], m[8],
                   1'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
